// File: rtl/onehot_encoder_buf.sv
// -----------------------------------------------------------------------------
// onehot_encoder_buf
//   Encodes a 4-bit one-hot word into a 2-bit index, MSB priority:
//   bit3->00, bit2->01, bit1->10, bit0->11. Any word that is not exactly
//   one-hot (all-zero or multi-hot) is flagged with out_err. Words travel on
//   a valid/ready stream through a 2-entry in-order output buffer. Flagged
//   words are counted at push time in a saturating counter.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst        in   1          asynchronous reset, active-high
//   in_valid   in   1          in_onehot holds a valid word
//   in_ready   out  1          block accepts a word this cycle
//   in_onehot  in   4          one-hot word, bit3 maps to code 00
//   out_valid  out  1          out_code/out_err hold the oldest result
//   out_ready  in   1          consumer takes the result this cycle
//   out_code   out  2          encoded index
//   out_err    out  1          source word was zero or multi-hot
//   err_clr    in   1          synchronous clear of err_count
//   err_count  out  ERR_CNT_W  saturating count of accepted error words
// -----------------------------------------------------------------------------
module onehot_encoder_buf #(
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           in_onehot,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [1:0]           out_code,
   output logic                 out_err,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

   // Returns {err, code[1:0]} for a 4-bit word.
   function automatic logic [2:0] encode_word(input logic [3:0] word);
      logic [1:0] code_v;
      logic [2:0] ones_v;
      ones_v = 3'd0;
      for (int i = 0; i < 4; i++) begin
         ones_v = ones_v + {2'b00, word[i]};
      end
      casez (word)
         4'b1???: code_v = 2'b00;
         4'b01??: code_v = 2'b01;
         4'b001?: code_v = 2'b10;
         4'b0001: code_v = 2'b11;
         default: code_v = 2'b00;   // all-zero word
      endcase
      return {(ones_v != 3'd1), code_v};
   endfunction

   // Buffer entries hold {err, code}; slot0_r is always the oldest entry.
   logic [2:0]           slot0_r;
   logic [2:0]           slot1_r;
   logic [1:0]           occ_r;
   logic                 rdy_en_r;   // low during reset and until the first edge after it
   logic [ERR_CNT_W-1:0] err_cnt_r;

   logic                 push_s;
   logic                 pop_s;
   logic [2:0]           enc_s;
   logic                 in_ready_s;

   // Handshake decode; ready depends on registered state only.
   always_comb begin
      enc_s      = encode_word(in_onehot);
      in_ready_s = rdy_en_r && (occ_r < 2'd2);
      push_s     = in_valid && in_ready_s;
      pop_s      = (occ_r != 2'd0) && out_ready;
   end

   // Two-entry in-order buffer and occupancy tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot0_r  <= 3'b000;
         slot1_r  <= 3'b000;
         occ_r    <= 2'd0;
         rdy_en_r <= 1'b0;
      end else begin
         rdy_en_r <= 1'b1;
         case ({push_s, pop_s})
            2'b10: begin
               if (occ_r == 2'd0) begin
                  slot0_r <= enc_s;
               end else begin
                  slot1_r <= enc_s;
               end
               occ_r <= occ_r + 2'd1;
            end
            2'b01: begin
               slot0_r <= slot1_r;
               occ_r   <= occ_r - 2'd1;
            end
            // Push and pop together only happen at occupancy 1 (push is
            // blocked at 2), so the new word simply replaces the head.
            2'b11: begin
               slot0_r <= enc_s;
            end
            default: begin
               slot0_r <= slot0_r;
            end
         endcase
      end
   end

   // Saturating error counter; a clear wins over a same-cycle error push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else if (err_clr) begin
         err_cnt_r <= {ERR_CNT_W{1'b0}};
      end else if (push_s && enc_s[2] && (err_cnt_r != ERR_MAX)) begin
         err_cnt_r <= err_cnt_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = (occ_r != 2'd0);
   assign out_code  = slot0_r[1:0];
   assign out_err   = slot0_r[2];
   assign err_count = err_cnt_r;

endmodule
